// File: rtl/tfe_pkg.sv
// ---------------------------------------------------------------------------
// tfe_pkg
// Shared definitions for the tile-game blocks: cell exponent codes, the
// spawner FSM state enum, and the 16-bit Galois LFSR tap mask together with
// a single-step helper used by the LFSR sub-module.
// ---------------------------------------------------------------------------
package tfe_pkg;

    // Cell exponent codes: 0 marks an empty cell, k marks a tile of value 2^k
    localparam int EXP_EMPTY = 0;
    localparam int EXP_TWO   = 1;
    localparam int EXP_FOUR  = 2;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_PICK,
        ST_SELECT,
        ST_DONE
    } spawnState_e;

    // One LFSR step: shift right, fold the tap mask in when a 1 falls out
    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/tfe_lfsr.sv
// ---------------------------------------------------------------------------
// tfe_lfsr
// Free-running 16-bit Galois LFSR. It advances on every rising clock edge and
// returns to the seed on reset. An all-zero seed would lock the register up,
// so it is replaced by 16'h0001.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   seed : reset value
//   q    : current LFSR state
// ---------------------------------------------------------------------------
module tfe_lfsr
    import tfe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Load a non-zero seed on reset, otherwise step every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q <= lfsrStep(q);
        end
    end

endmodule

// File: rtl/tile_spawner.sv
// ---------------------------------------------------------------------------
// tile_spawner
// Picks a uniformly-ish random empty cell on an N x N board and reports the
// new tile exponent (1 = "2", 2 = "4"). The board is snapshotted on start.
// The block counts the empty cells, reduces a random number modulo that count
// by repeated subtraction, and then scans for the r-th empty cell. The block
// never writes the board.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : spawn request, honoured only while idle
//   board_in   : flattened board, cell i at [i*EW +: EW]
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle result strobe
//   full       : no empty cell in the snapshot
//   spawn_idx  : chosen cell index
//   spawn_exp  : spawned exponent, 0 when full
//   empty_cnt  : empty cells counted in the snapshot
// ---------------------------------------------------------------------------
module tile_spawner
    import tfe_pkg::*;
#(
    parameter int          N      = 4,
    parameter int          EW     = 5,
    parameter int unsigned P_FOUR = 26,
    parameter logic [15:0] SEED   = 16'hACE1,
    localparam int         C      = N * N,
    localparam int         IW     = $clog2(C),
    localparam int         CW     = $clog2(C + 1)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [C*EW-1:0] board_in,
    output logic            busy,
    output logic            done,
    output logic            full,
    output logic [IW-1:0]   spawn_idx,
    output logic [EW-1:0]   spawn_exp,
    output logic [CW-1:0]   empty_cnt
);

    // Width of the random draw reduced in PICK
    localparam int RW = IW + 4;

    spawnState_e     state_q, state_d;
    logic [C*EW-1:0] snapshot_q, snapshot_d;
    logic [15:0]     rnd_q, rnd_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   seen_q, seen_d;
    logic [CW-1:0]   emptyCnt_q, emptyCnt_d;
    logic            full_q, full_d;
    logic [IW-1:0]   spawnIdx_q, spawnIdx_d;
    logic [EW-1:0]   spawnExp_q, spawnExp_d;
    logic [15:0]     lfsrQ;
    logic            cellEmpty;
    logic [CW-1:0]   countNext;

    tfe_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (lfsrQ)
    );

    // COUNT and SELECT both walk the snapshot one cell per cycle through idx_q
    assign cellEmpty = (snapshot_q[int'(idx_q) * EW +: EW] == EW'(EXP_EMPTY));
    assign countNext = emptyCnt_q + CW'(cellEmpty);

    // Next-state and datapath updates; every register holds unless its state acts
    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        rnd_d      = rnd_q;
        idx_d      = idx_q;
        r_d        = r_q;
        seen_d     = seen_q;
        emptyCnt_d = emptyCnt_q;
        full_d     = full_q;
        spawnIdx_d = spawnIdx_q;
        spawnExp_d = spawnExp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snapshot_d = board_in;
                    rnd_d      = lfsrQ;
                    idx_d      = '0;
                    r_d        = '0;
                    seen_d     = '0;
                    emptyCnt_d = '0;
                    full_d     = 1'b0;
                    spawnIdx_d = '0;
                    spawnExp_d = '0;
                    state_d    = ST_COUNT;
                end
            end
            ST_COUNT: begin
                emptyCnt_d = countNext;
                if (idx_q == IW'(C - 1)) begin
                    idx_d = '0;
                    if (countNext == '0) begin
                        full_d     = 1'b1;
                        spawnIdx_d = '0;
                        spawnExp_d = '0;
                        state_d    = ST_DONE;
                    end else begin
                        r_d     = rnd_q[RW-1:0];
                        state_d = ST_PICK;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PICK: begin
                // Modulo by repeated subtraction keeps the datapath to one subtractor
                if (r_q >= RW'(emptyCnt_q)) begin
                    r_d = r_q - RW'(emptyCnt_q);
                end else begin
                    idx_d   = '0;
                    seen_d  = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // r < empty count, so the match is always found before idx wraps
                idx_d = idx_q + 1'b1;
                if (cellEmpty) begin
                    if (RW'(seen_q) == r_q) begin
                        spawnIdx_d = idx_q;
                        spawnExp_d = (32'(rnd_q[15:8]) < P_FOUR) ? EW'(EXP_FOUR) : EW'(EXP_TWO);
                        state_d    = ST_DONE;
                    end else begin
                        seen_d = seen_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snapshot_q <= '0;
            rnd_q      <= '0;
            idx_q      <= '0;
            r_q        <= '0;
            seen_q     <= '0;
            emptyCnt_q <= '0;
            full_q     <= 1'b0;
            spawnIdx_q <= '0;
            spawnExp_q <= '0;
        end else begin
            state_q    <= state_d;
            snapshot_q <= snapshot_d;
            rnd_q      <= rnd_d;
            idx_q      <= idx_d;
            r_q        <= r_d;
            seen_q     <= seen_d;
            emptyCnt_q <= emptyCnt_d;
            full_q     <= full_d;
            spawnIdx_q <= spawnIdx_d;
            spawnExp_q <= spawnExp_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign full      = full_q;
    assign spawn_idx = spawnIdx_q;
    assign spawn_exp = spawnExp_q;
    assign empty_cnt = emptyCnt_q;

endmodule
